// File: rtl/sci_exec_ctrl.sv
// sci_exec_ctrl: multi-cycle sequencer driving the SCI register-file/ALU datapath for I-type instructions.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   inst_valid/inst_ready     instruction handshake; inst is the 32-bit word
//   op_code, rd_reg1, imme    decoded opcode [31:26], read index [25:21], immediate [15:0]
//   wr_reg, wr_enable         write index [20:16] and one-cycle register-file write strobe
//   sel_ch                    operand select, always the register operand (0)
//   busy, done, illegal       in-flight flag, one-cycle retire pulse, sticky unsupported-opcode flag
// Optional: define SCI_EXEC_CTRL_PERF_EN to add retired_cnt[15:0] and illegal_cnt[7:0].
module sci_exec_ctrl #(
  parameter int OPW = 6,
  parameter int REGW = 5,
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  output logic [REGW-1:0] rd_reg1,
  output logic [15:0]     imme,
  output logic [OPW-1:0]  op_code,
  output logic            sel_ch,
  output logic            wr_enable,
  output logic [REGW-1:0] wr_reg,
  output logic            busy,
  output logic            done,
  output logic            illegal
`ifdef SCI_EXEC_CTRL_PERF_EN
  ,
  output logic [15:0]     retired_cnt,
  output logic [7:0]      illegal_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB, DONE} state_t;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic       legal;
  assign legal = (op_code == OPW'(6'b001000)) || (op_code == OPW'(6'b001100)) ||
                 (op_code == OPW'(6'b001101));
  assign sel_ch = 1'b0;
  // Outputs are registered alongside the state transition so they line up with the state entered.
  // An unsupported opcode passes through WB with the strobe held low, giving it a two-cycle retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inst_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_enable  <= 1'b0;
      illegal    <= 1'b0;
      op_code    <= '0;
      rd_reg1    <= '0;
      wr_reg     <= '0;
      imme       <= '0;
`ifdef SCI_EXEC_CTRL_PERF_EN
      retired_cnt <= '0;
      illegal_cnt <= '0;
`endif
    end else begin
      wr_enable <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        IDLE: if (inst_valid) begin
          op_code    <= inst[31 -: OPW];
          rd_reg1    <= inst[21 +: REGW];
          wr_reg     <= inst[16 +: REGW];
          imme       <= inst[15:0];
          inst_ready <= 1'b0;
          busy       <= 1'b1;
          state_q    <= DECODE;
        end
        DECODE: if (legal) begin
          state_q <= READ;
        end else begin
          illegal <= 1'b1;
          state_q <= WB;
`ifdef SCI_EXEC_CTRL_PERF_EN
          illegal_cnt <= illegal_cnt + 8'd1;
`endif
        end
        READ: begin
          cnt_q   <= 4'(EXEC_CYCLES - 1);
          state_q <= EXEC;
        end
        EXEC: if (cnt_q == '0) begin
          wr_enable <= (wr_reg != '0);
          state_q   <= WB;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        WB: begin
          done    <= 1'b1;
          state_q <= DONE;
`ifdef SCI_EXEC_CTRL_PERF_EN
          retired_cnt <= retired_cnt + 16'd1;
`endif
        end
        DONE: begin
          inst_ready <= 1'b1;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sci_exec_ctrl.sv
// tb_sci_exec_ctrl: scoreboard bench for sci_exec_ctrl with EXEC_CYCLES=1 and EXEC_CYCLES=4 instances.
module tb_sci_exec_ctrl;
  typedef struct packed {
    int wr_t; int wr_n; int done_t; int done_n; int rdy_t;
    logic ill1; logic [5:0] op; logic [4:0] rd; logic [4:0] wr; logic [15:0] imm;
  } rec_t;
  logic clk = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic rst_a[2], valid[2], ready[2], sel[2], wr_en[2], busy[2], done[2], ill[2];
  logic [31:0] ins[2];
  logic [4:0] rd[2], wr[2];
  logic [15:0] imm[2];
  logic [5:0] op[2];
`ifdef SCI_EXEC_CTRL_PERF_EN
  logic [15:0] ret[2];
  logic [7:0] icnt[2];
`endif
  int errors = 0, checks = 0, acc_cyc;
  logic m_ill[2];
  rec_t obs;
  rec_t sb[$];
  sci_exec_ctrl #(.EXEC_CYCLES(1)) u1 (
    .clk(clk), .rst(rst_a[0]), .inst_valid(valid[0]), .inst_ready(ready[0]), .inst(ins[0]),
    .rd_reg1(rd[0]), .imme(imm[0]), .op_code(op[0]), .sel_ch(sel[0]), .wr_enable(wr_en[0]),
    .wr_reg(wr[0]), .busy(busy[0]), .done(done[0]), .illegal(ill[0])
`ifdef SCI_EXEC_CTRL_PERF_EN
    , .retired_cnt(ret[0]), .illegal_cnt(icnt[0])
`endif
  );
  sci_exec_ctrl #(.EXEC_CYCLES(4)) u4 (
    .clk(clk), .rst(rst_a[1]), .inst_valid(valid[1]), .inst_ready(ready[1]), .inst(ins[1]),
    .rd_reg1(rd[1]), .imme(imm[1]), .op_code(op[1]), .sel_ch(sel[1]), .wr_enable(wr_en[1]),
    .wr_reg(wr[1]), .busy(busy[1]), .done(done[1]), .illegal(ill[1])
`ifdef SCI_EXEC_CTRL_PERF_EN
    , .retired_cnt(ret[1]), .illegal_cnt(icnt[1])
`endif
  );

  function automatic rec_t model(input int ec, input logic [31:0] w, input logic ib);
    rec_t e;
    logic legal;
    legal = w[31:26] inside {6'b001000, 6'b001100, 6'b001101};
    e.op = w[31:26]; e.rd = w[25:21]; e.wr = w[20:16]; e.imm = w[15:0];
    e.ill1 = ib | ~legal;
    e.wr_n = (legal && w[20:16] != 5'd0) ? 1 : 0;
    e.wr_t = (e.wr_n != 0) ? 2 + ec : -1;
    e.done_t = legal ? 3 + ec : 2;
    e.done_n = 1;
    e.rdy_t = e.done_t + 1;
    return e;
  endfunction

  task automatic do_reset(input int d);
    rst_a[d] = 1; valid[d] = 0;
    repeat (2) @(negedge clk);
    rst_a[d] = 0; m_ill[d] = 0;
    @(negedge clk);
  endtask

  // Accepts one instruction and records what the DUT does, relative to the accept edge, until ready returns.
  task automatic issue(input int d, input logic [31:0] w, input bit tog);
    int g = 0;
    while (ready[d] !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    valid[d] = 1; ins[d] = w;
    @(negedge clk);
    valid[d] = 0; ins[d] = '0; acc_cyc = cyc;
    obs = '0; obs.wr_t = -1; obs.done_t = -1; obs.rdy_t = -1;
    obs.op = op[d]; obs.rd = rd[d]; obs.wr = wr[d]; obs.imm = imm[d];
    for (int k = 1; k <= 40 && obs.rdy_t < 0; k++) begin
      if (tog) begin valid[d] = (k < 4) && k[0]; ins[d] = 32'h3400_0000 | 32'(k); end
      @(negedge clk);
      if (wr_en[d] === 1'b1) begin if (obs.wr_t < 0) obs.wr_t = k; obs.wr_n++; end
      if (done[d] === 1'b1) begin if (obs.done_t < 0) obs.done_t = k; obs.done_n++; end
      if (k == 1) obs.ill1 = ill[d];
      if (ready[d] === 1'b1 && obs.rdy_t < 0) obs.rdy_t = k;
    end
    valid[d] = 0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      checks++;
      if ({ready[d], busy[d], done[d], wr_en[d], ill[d], sel[d]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b, expected 100000", d,
                 {ready[d], busy[d], done[d], wr_en[d], ill[d], sel[d]});
      end
      checks++;
      if ({op[d], rd[d], wr[d], imm[d]} !== 32'h0) begin
        errors++;
        $display("FAIL reset_fields[%0d]: got %h, expected 0", d, {op[d], rd[d], wr[d], imm[d]});
      end
    end
  endtask

  task automatic test_legal;
    logic [31:0] tbl[6] = '{32'h2002_0005, 32'h2000_0007, 32'h3485_1234, 32'h3043_00FF,
                            32'h3043_00FF, 32'h2002_0005};
    rec_t e;
    for (int i = 0; i < 6; i++) begin
      int d = (i < 4) ? 0 : 1;
      sb.push_back(model(d ? 4 : 1, tbl[i], m_ill[d]));
      issue(d, tbl[i], d == 1);
      e = sb.pop_front();
      m_ill[d] = e.ill1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL legal[%0d]: got %h, expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    rec_t e;
    int a0;
    sb.push_back(model(1, 32'h3485_1234, m_ill[0]));
    sb.push_back(model(1, 32'h2002_0005, m_ill[0]));
    issue(0, 32'h3485_1234, 0);
    a0 = acc_cyc;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_first: got %h, expected %h", obs, e); end
    issue(0, 32'h2002_0005, 0);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL b2b_second: got %h, expected %h", obs, e); end
    checks++;
    if (acc_cyc - a0 !== 6) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles, expected 6", acc_cyc - a0);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] tbl[3] = '{32'hFC22_0001, 32'h3485_1234, 32'h0001_0000};
    rec_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(1, tbl[i], m_ill[0]));
      issue(0, tbl[i], 0);
      e = sb.pop_front();
      m_ill[0] = e.ill1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h, expected %h", i, obs, e);
      end
    end
    do_reset(0);
    checks++;
    if (ill[0] !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b, expected 0", ill[0]); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    while (ready[1] !== 1'b1) @(negedge clk);
    valid[1] = 1; ins[1] = 32'h3043_00FF;
    @(negedge clk);
    valid[1] = 0;
    repeat (3) begin
      @(negedge clk);
      pulses += int'(wr_en[1] === 1'b1) + int'(done[1] === 1'b1);
    end
    rst_a[1] = 1;
    @(negedge clk);
    rst_a[1] = 0;
    checks++;
    if ({ready[1], busy[1], wr_en[1], done[1]} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset_idle: got %b, expected 1000", {ready[1], busy[1], wr_en[1], done[1]});
    end
    checks++;
    if (op[1] !== 6'd0) begin errors++; $display("FAIL mid_reset_op: got %h, expected 00", op[1]); end
    repeat (10) begin
      @(negedge clk);
      pulses += int'(wr_en[1] === 1'b1) + int'(done[1] === 1'b1);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL mid_reset_pulses: got %0d, expected 0", pulses); end
  endtask

`ifdef SCI_EXEC_CTRL_PERF_EN
  task automatic test_perf;
    logic [31:0] tbl[4] = '{32'h2002_0005, 32'hFC22_0001, 32'h3485_1234, 32'h3043_00FF};
    do_reset(0);
    foreach (tbl[i]) issue(0, tbl[i], 0);
    checks++;
    if (ret[0] !== 16'd4) begin errors++; $display("FAIL perf_retired: got %0d, expected 4", ret[0]); end
    checks++;
    if (icnt[0] !== 8'd1) begin errors++; $display("FAIL perf_illegal: got %0d, expected 1", icnt[0]); end
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1; valid[d] = 0; ins[d] = '0; m_ill[d] = 0;
    end
    test_reset;
    test_legal;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
`ifdef SCI_EXEC_CTRL_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
